// File: rtl/rng_entropy_collector.sv
// Entropy collector for the 8-bit ring-oscillator RNG array: warm-up, divided sampling,
// repetition-count health test, word packing and valid/ready hand-off.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | oscillators off, waiting for start
// S_WARMUP  | oscillators on, warm-up down-counter running
// S_COLLECT | sampling every SAMPLE_DIV cycles, packing bytes, health test
// S_VALID   | word presented, waiting for rnd_ready
// S_FAULT   | sticky health-test failure, oscillators off
module rng_entropy_collector #(
    parameter int WARMUP_CYCLES = 16,
    parameter int SAMPLE_DIV    = 4,
    parameter int REP_LIMIT     = 4,
    parameter int WORD_BYTES    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear_fault,
    input  logic [7:0]              raw_byte,
    output logic                    rng_enable,
    output logic [8*WORD_BYTES-1:0] rnd_word,
    output logic                    rnd_valid,
    input  logic                    rnd_ready,
    output logic                    busy,
    output logic                    fault
);

    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int BW = $clog2(WORD_BYTES + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    localparam logic [WW-1:0] WARM_LOAD = WW'(WARMUP_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);
    localparam logic [RW-1:0] REP_TRIP  = RW'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_VALID,
        S_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [WW-1:0]           warm_q, warm_d;
    logic [DW-1:0]           div_q, div_d;
    logic [BW-1:0]           byte_q, byte_d;
    logic [RW-1:0]           rep_q, rep_d;
    logic [RW-1:0]           rep_next;
    logic [7:0]              prev_q, prev_d;
    logic [8*WORD_BYTES-1:0] word_q, word_d;
    logic [7:0]              sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_byte;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            warm_q  <= '0;
            div_q   <= '0;
            byte_q  <= '0;
            rep_q   <= '0;
            prev_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            div_q   <= div_d;
            byte_q  <= byte_d;
            rep_q   <= rep_d;
            prev_q  <= prev_d;
            word_q  <= word_d;
        end
    end

    // rep_q == 0 marks an empty history, so the first sample of a run always starts at 1
    always_comb begin
        if ((rep_q != '0) && (sync2_q == prev_q)) begin
            rep_next = rep_q + RW'(1);
        end else begin
            rep_next = RW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        div_d   = div_q;
        byte_d  = byte_q;
        rep_d   = rep_q;
        prev_d  = prev_q;
        word_d  = word_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WARMUP;
                    warm_d  = WARM_LOAD;
                    rep_d   = '0;
                end
            end
            S_WARMUP: begin
                if (warm_q == '0) begin
                    state_d = S_COLLECT;
                    div_d   = '0;
                    byte_d  = '0;
                end else begin
                    warm_d = warm_q - WW'(1);
                end
            end
            S_COLLECT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    rep_d  = rep_next;
                    prev_d = sync2_q;
                    // health trip wins over word completion on the same sample
                    if (rep_next == REP_TRIP) begin
                        state_d = S_FAULT;
                        word_d  = '0;
                    end else begin
                        for (int k = 0; k < WORD_BYTES; k++) begin
                            if (byte_q == BW'(k)) begin
                                word_d[8*k +: 8] = sync2_q;
                            end
                        end
                        if (byte_q == BYTE_LAST) begin
                            state_d = S_VALID;
                        end else begin
                            byte_d = byte_q + BW'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_VALID: begin
                if (rnd_ready) begin
                    if (start) begin
                        state_d = S_COLLECT;
                        div_d   = '0;
                        byte_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rng_enable = (state_q == S_WARMUP) || (state_q == S_COLLECT) || (state_q == S_VALID);
    assign busy       = (state_q == S_WARMUP) || (state_q == S_COLLECT);
    assign rnd_valid  = (state_q == S_VALID);
    assign fault      = (state_q == S_FAULT);
    assign rnd_word   = word_q;

endmodule

// File: tb/tb_rng_entropy_collector.sv
// Bench for rng_entropy_collector: directed scenarios plus random traffic, all outputs
// compared each cycle against a timeline-based reference model.
module tb_rng_entropy_collector;

    localparam int W  = 16;
    localparam int SD = 4;
    localparam int RL = 4;
    localparam int WB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear_fault = 1'b0;
    logic          rnd_ready = 1'b0;
    logic [7:0]    raw_byte = 8'h00;
    logic          rng_enable;
    logic [8*WB-1:0] rnd_word;
    logic          rnd_valid;
    logic          busy;
    logic          fault;

    int vectors = 0;
    int miscompares = 0;

    rng_entropy_collector #(
        .WARMUP_CYCLES(W),
        .SAMPLE_DIV(SD),
        .REP_LIMIT(RL),
        .WORD_BYTES(WB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .clear_fault(clear_fault),
        .raw_byte(raw_byte),
        .rng_enable(rng_enable),
        .rnd_word(rnd_word),
        .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready),
        .busy(busy),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 word offered, 3 faulted.
    // While running, samples fall at warm-up length + SD*(n+1) edges after the run began.
    int          m_mode = 0;
    int          m_t = 0;
    int          m_warm = 0;
    int          m_n = 0;
    int          m_runlen = 0;
    logic        m_have = 1'b0;
    logic [7:0]  m_last = 8'h00;
    logic [7:0]  m_r1 = 8'h00;
    logic [7:0]  m_r2 = 8'h00;
    logic [7:0]  m_bytes [WB];

    function automatic logic [8*WB-1:0] exp_word();
        logic [8*WB-1:0] w;
        w = '0;
        for (int k = 0; k < WB; k++) w[8*k +: 8] = m_bytes[k];
        return w;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_r1 = 8'h00;
        m_r2 = 8'h00;
        m_have = 1'b0;
        m_runlen = 0;
    endtask

    // Advance by one rising edge using the inputs that edge will see.
    task automatic model_step();
        logic [7:0] s;
        s = m_r2;
        m_r2 = m_r1;
        m_r1 = raw_byte;
        case (m_mode)
            0: if (start) begin
                m_mode = 1; m_t = 0; m_warm = W; m_n = 0; m_have = 1'b0;
            end
            1: begin
                m_t++;
                if (m_t == m_warm + SD * (m_n + 1)) begin
                    m_runlen = (m_have && s == m_last) ? m_runlen + 1 : 1;
                    m_last = s;
                    m_have = 1'b1;
                    if (m_runlen >= RL) begin
                        m_mode = 3;
                    end else begin
                        m_bytes[m_n] = s;
                        m_n++;
                        if (m_n == WB) m_mode = 2;
                    end
                end
            end
            2: if (rnd_ready) begin
                if (start) begin
                    m_mode = 1; m_t = 0; m_warm = 0; m_n = 0;
                end else begin
                    m_mode = 0;
                end
            end
            3: if (clear_fault) m_mode = 0;
            default: m_mode = 0;
        endcase
    endtask

    initial begin
        for (int k = 0; k < WB; k++) m_bytes[k] = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_enable", 64'(rng_enable), 64'd0);
                check("rst_valid", 64'(rnd_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_fault", 64'(fault), 64'd0);
                check("rst_word", 64'(rnd_word), 64'd0);
                model_reset();
            end else begin
                check("rng_enable", 64'(rng_enable), 64'(m_mode == 1 || m_mode == 2));
                check("rnd_valid", 64'(rnd_valid), 64'(m_mode == 2));
                check("busy", 64'(busy), 64'(m_mode == 1));
                check("fault", 64'(fault), 64'(m_mode == 3));
                if (m_mode == 2) check("rnd_word", 64'(rnd_word), 64'(exp_word()));
                model_step();
            end
        end
    end

    logic [7:0] pat [8];

    // Edge 0 is the first edge after the call; raw byte for sample k is held around its capture.
    task automatic collect(input int off, input int kbase, input int pulse_n,
                           input logic keep_ready, output int n);
        bit done;
        int k;
        n = 0;
        done = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            start = (pulse_n >= 0) && (n == pulse_n || n == pulse_n + 17);
            rnd_ready = keep_ready;
            k = (n >= off) ? kbase + (n - off) / SD : kbase;
            if (k > 7) k = 7;
            raw_byte = pat[k];
            if (rnd_valid || fault) begin
                done = 1;
            end else if (n >= 200) begin
                vectors++;
                miscompares++;
                $display("FAIL collect_timeout: got no valid/fault after %0d edges, expected within 200", n);
                done = 1;
            end else begin
                n++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_enable", 64'(rng_enable), 64'd0);
        check("reset_word", 64'(rnd_word), 64'd0);

        // 1) basic word, latency, return to idle
        rnd_ready = 1'b1;
        start = 1'b1;
        collect(W, 0, -1, 1'b1, n);
        check("t1_latency", 64'(n + 1), 64'd33);
        check("t1_word", 64'(rnd_word), 64'h44332211);
        tick();
        check("t1_idle_enable", 64'(rng_enable), 64'd0);
        check("t1_valid_drop", 64'(rnd_valid), 64'd0);

        // 2) back-pressure then back-to-back word without warm-up
        rnd_ready = 1'b0;
        start = 1'b1;
        collect(W, 0, -1, 1'b0, n);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_hold_valid", 64'(rnd_valid), 64'd1);
            check("t2_hold_word", 64'(rnd_word), 64'h44332211);
        end
        rnd_ready = 1'b1;
        start = 1'b1;
        collect(0, 4, -1, 1'b0, n);
        check("t2_gap", 64'(n), 64'd16);
        check("t2_word", 64'(rnd_word), 64'h88776655);
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;

        // 3) stuck oscillator trips the fault
        pat = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        start = 1'b1;
        collect(W, 0, -1, 1'b0, n);
        check("t3_fault_edge", 64'(n), 64'd32);
        check("t3_fault", 64'(fault), 64'd1);
        check("t3_enable_off", 64'(rng_enable), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t3_start_ignored", 64'(fault), 64'd1);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("t3_cleared", 64'(fault), 64'd0);

        // 4) repetition counted across a word boundary
        pat = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        start = 1'b1;
        collect(W, 0, -1, 1'b0, n);
        check("t4_no_fault", 64'(fault), 64'd0);
        check("t4_word", 64'(rnd_word), 64'h3CA5A5A5);
        rnd_ready = 1'b1;
        start = 1'b1;
        collect(0, 4, -1, 1'b0, n);
        check("t4_fault", 64'(fault), 64'd1);
        check("t4_fault_edge", 64'(n), 64'd12);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;

        // 5) asynchronous reset mid-collection and in fault
        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (22) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_enable", 64'(rng_enable), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        collect(W, 0, -1, 1'b0, n);
        check("t5_full_warmup", 64'(n + 1), 64'd33);
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        pat = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        start = 1'b1;
        collect(W, 0, -1, 1'b0, n);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_fault", 64'(fault), 64'd0);
        tick();
        rst_n = 1'b1;

        // 6) ignored start pulses and clear_fault outside fault
        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        start = 1'b1;
        collect(W, 0, 5, 1'b0, n);
        check("t6_latency", 64'(n + 1), 64'd33);
        check("t6_word", 64'(rnd_word), 64'h44332211);
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("t6_idle_enable", 64'(rng_enable), 64'd0);
        check("t6_idle_busy", 64'(busy), 64'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            start = ($urandom_range(0, 9) == 0);
            rnd_ready = 1'($urandom_range(0, 1));
            clear_fault = ($urandom_range(0, 7) == 0);
            raw_byte = 8'($urandom_range(0, 2));
        end
        start = 1'b0;
        clear_fault = 1'b0;
        rnd_ready = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
